// File: rtl/cv32e40p_wb_buffer_pkg.sv
// Shared types and defaults for the write-back buffer.
// Holds the entry layout and default sizes.
package cv32e40p_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 6;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_DEPTH      = 4;

    // live=0 marks an entry that drains without writing
    typedef struct packed {
        logic                     live;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic addr_hit(
        input logic [WB_ADDR_WIDTH-1:0] a,
        input logic [WB_ADDR_WIDTH-1:0] b
    );
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/cv32e40p_wb_buffer.sv
// In-order write-back buffer feeding register-file port W2.
// Ports: push side (valid/ready/addr/data), W1 snoop (we_a/waddr_a),
// three read-hazard ports, W2 write outputs and empty flag.
module cv32e40p_wb_buffer
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned DEPTH      = WB_DEPTH
) (
    input  logic                  clk_int,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  hazard_c_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic                  live;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;

    logic            empty;
    logic            pop;
    logic            push_acc;
    logic            kill_en;
    logic            kill_head;
    entry_t          head;
    logic [DEPTH-1:0] held;
    logic [DEPTH-1:0] kill_vec;
    logic [ADDR_WIDTH-1:0] raddr [3];
    logic [2:0]      hz;

    assign empty     = (count == '0);
    assign pop       = ~empty;
    assign push_ready_o = (count != CNT_FULL);
    assign push_acc  = push_valid_i & push_ready_o;
    assign kill_en   = we_a_i & (waddr_a_i != '0);
    assign head      = mem[rd_ptr];
    assign kill_head = kill_en & (head.addr == waddr_a_i);

    // W1 wins the regfile race only if W2 stays quiet this cycle
    assign we_b_o    = pop & head.live & ~kill_head;
    assign waddr_b_o = empty ? '0 : head.addr;
    assign wdata_b_o = empty ? '0 : head.data;
    assign empty_o   = empty;

    assign raddr[0] = raddr_a_i;
    assign raddr[1] = raddr_b_i;
    assign raddr[2] = raddr_c_i;

    // held: slot lies inside the occupied window starting at rd_ptr
    always_comb begin
        logic [PW-1:0] off;
        held     = '0;
        kill_vec = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = PW'(i) - rd_ptr;
            held[i]     = ({1'b0, off} < count);
            kill_vec[i] = kill_en & (mem[i].addr == waddr_a_i);
        end
    end

    always_comb begin
        hz = '0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (held[i] && mem[i].live && !kill_vec[i] &&
                    mem[i].addr == raddr[p])
                    hz[p] = 1'b1;
            end
            if (push_acc && push_addr_i == raddr[p])
                hz[p] = 1'b1;
            if (raddr[p] == '0)
                hz[p] = 1'b0;
        end
    end

    assign hazard_a_o = hz[0];
    assign hazard_b_o = hz[1];
    assign hazard_c_o = hz[2];

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_vec[i])
                    mem[i].live <= 1'b0;
            // written after the kill loop: a same-cycle push is younger
            if (push_acc) begin
                mem[wr_ptr] <= '{live: (push_addr_i != '0),
                                 addr: push_addr_i,
                                 data: push_data_i};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
